// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: lights one LFSR-chosen target at a time, times the
// show/gap windows, judges synchronised button presses and keeps saturating score/miss counts.
module mole_round_ctrl #(
  parameter int N_MOLES   = 4,
  parameter int SHOW_CYC  = 50_000_000,
  parameter int GAP_CYC   = 12_500_000,
  parameter int ROUND_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [N_MOLES-1:0] i_btn,
  output logic [N_MOLES-1:0] o_mole,
  output logic [CNT_W-1:0]   o_score,
  output logic [CNT_W-1:0]   o_misses,
  output logic               o_hit_pulse,
  output logic               o_busy,
  output logic               o_done
);
  localparam int               IDX_W     = $clog2(N_MOLES);
  localparam int               TMR_MAX   = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
  localparam int               TMR_W     = $clog2(TMR_MAX) + 1;
  localparam logic [TMR_W-1:0] SHOW_LOAD = TMR_W'(SHOW_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [7:0]       ROUND_END = 8'(ROUND_LEN);

  typedef enum logic [2:0] {S_IDLE, S_PICK, S_SHOW, S_GAP, S_DONE} state_t;

  state_t             r_state, w_state;
  logic [N_MOLES-1:0] r_sync1, r_sync2, r_prev, r_press;
  logic [7:0]         r_lfsr;
  logic [IDX_W-1:0]   r_last, w_last, w_idx_raw, w_idx;
  logic [N_MOLES-1:0] r_mole, w_mole, w_onehot;
  logic [TMR_W-1:0]   r_timer, w_timer;
  logic [7:0]         r_round, w_round, w_round_inc;
  logic [CNT_W-1:0]   r_score, w_score, r_misses, w_misses;
  logic               r_hit, w_hit;
  logic               w_lit_hit, w_wrong;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Buttons idle high, so the synchroniser resets to 1 to avoid a phantom press
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
      r_press <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_press <= r_prev & ~r_sync2;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_lfsr <= 8'hA5;
    else          r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  assign w_idx_raw   = r_lfsr[IDX_W-1:0];
  assign w_idx       = (w_idx_raw == r_last) ? w_idx_raw + IDX_W'(1) : w_idx_raw;
  assign w_onehot    = N_MOLES'(1) << w_idx;
  assign w_lit_hit   = |(r_press & r_mole);
  assign w_wrong     = |(r_press & ~r_mole);
  assign w_round_inc = r_round + 8'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_last   <= '0;
      r_mole   <= '0;
      r_timer  <= '0;
      r_round  <= '0;
      r_score  <= '0;
      r_misses <= '0;
      r_hit    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_last   <= w_last;
      r_mole   <= w_mole;
      r_timer  <= w_timer;
      r_round  <= w_round;
      r_score  <= w_score;
      r_misses <= w_misses;
      r_hit    <= w_hit;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_last   = r_last;
    w_mole   = r_mole;
    w_timer  = r_timer;
    w_round  = r_round;
    w_score  = r_score;
    w_misses = r_misses;
    w_hit    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state  = S_PICK;
          w_score  = '0;
          w_misses = '0;
          w_round  = '0;
        end
      end
      S_PICK: begin
        w_last  = w_idx;
        w_timer = SHOW_LOAD;
        w_mole  = w_onehot;
        w_state = S_SHOW;
      end
      S_SHOW: begin
        if (w_lit_hit) begin
          w_score = sat_inc(r_score);
          w_hit   = 1'b1;
          w_mole  = '0;
          w_timer = GAP_LOAD;
          w_state = S_GAP;
        end else if (w_wrong) begin
          // Timer holds at zero so the escape is still taken on the next cycle
          w_misses = sat_inc(r_misses);
          if (r_timer != '0) w_timer = r_timer - TMR_W'(1);
        end else if (r_timer == '0) begin
          w_misses = sat_inc(r_misses);
          w_mole   = '0;
          w_timer  = GAP_LOAD;
          w_state  = S_GAP;
        end else begin
          w_timer = r_timer - TMR_W'(1);
        end
      end
      S_GAP: begin
        if (r_timer == '0) begin
          w_round = w_round_inc;
          w_state = (w_round_inc == ROUND_END) ? S_DONE : S_PICK;
        end else begin
          w_timer = r_timer - TMR_W'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign o_mole      = r_mole;
  assign o_score     = r_score;
  assign o_misses    = r_misses;
  assign o_hit_pulse = r_hit;
  assign o_busy      = (r_state == S_PICK) || (r_state == S_SHOW) || (r_state == S_GAP);
  assign o_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Self-checking bench for mole_round_ctrl: a short-round instance for timing/judgement
// scenarios and a 255-mole instance for saturation and non-repeating picks.
module tb_mole_round_ctrl;
  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, hit, busy, done;
  logic [3:0] btn, mole;
  logic [4:0] score, misses;
  logic       rst2_n, start2, hit2, busy2, done2;
  logic [3:0] btn2, mole2;
  logic [4:0] score2, misses2;

  mole_round_ctrl #(.N_MOLES(4), .SHOW_CYC(20), .GAP_CYC(5), .ROUND_LEN(4), .CNT_W(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_btn(btn), .o_mole(mole),
    .o_score(score), .o_misses(misses), .o_hit_pulse(hit), .o_busy(busy), .o_done(done));

  mole_round_ctrl #(.N_MOLES(4), .SHOW_CYC(6), .GAP_CYC(2), .ROUND_LEN(255), .CNT_W(5)) dut2 (
    .i_clk(clk), .i_rst_n(rst2_n), .i_start(start2), .i_btn(btn2), .o_mole(mole2),
    .o_score(score2), .o_misses(misses2), .o_hit_pulse(hit2), .o_busy(busy2), .o_done(done2));

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int exp_q2[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int onehot_idx(input logic [3:0] m);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (m == (4'b0001 << i)) r = i;
    return r;
  endfunction

  task automatic wait_lit(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mole != 4'd0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_lit2(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mole2 != 4'd0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; btn = 4'hF;
    rst2_n = 1'b0; start2 = 1'b0; btn2 = 4'hF;
    repeat (3) tick();
    n_tests++; if (mole !== 4'd0)   begin n_fail++; $display("FAIL reset_mole got %b want 0000", mole); end
    n_tests++; if (score !== 5'd0)  begin n_fail++; $display("FAIL reset_score got %0d want 0", score); end
    n_tests++; if (misses !== 5'd0) begin n_fail++; $display("FAIL reset_misses got %0d want 0", misses); end
    n_tests++; if ({hit, busy, done} !== 3'b000)
      begin n_fail++; $display("FAIL reset_flags hit/busy/done got %b want 000", {hit, busy, done}); end
    rst_n = 1'b1; rst2_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_no_press();
    bit ok;
    int idx, prev, lit, dark;
    start = 1'b1; tick(); start = 1'b0;
    n_tests++; if (busy !== 1'b1 || mole !== 4'd0)
      begin n_fail++; $display("FAIL start_pick busy=%b mole=%b want busy=1 mole=0000", busy, mole); end
    tick();
    n_tests++; if (onehot_idx(mole) < 0)
      begin n_fail++; $display("FAIL start_latency mole=%b want one-hot two edges after start", mole); end
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      wait_lit(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL nopress_lit_timeout mole %0d never lit", k); return; end
      idx = onehot_idx(mole);
      n_tests++; if (idx < 0 || idx == prev)
        begin n_fail++; $display("FAIL nopress_idx mole=%b prev idx %0d", mole, prev); end
      prev = idx;
      lit = 0;
      while (mole != 4'd0 && lit < 100) begin lit++; tick(); end
      n_tests++; if (lit != 20) begin n_fail++; $display("FAIL nopress_show_len got %0d want 20", lit); end
      dark = 0;
      while (mole == 4'd0 && done == 1'b0 && dark < 100) begin dark++; tick(); end
      n_tests++; if (dark != ((k < 3) ? 6 : 5))
        begin n_fail++; $display("FAIL nopress_dark_len got %0d want %0d", dark, (k < 3) ? 6 : 5); end
    end
    n_tests++; if (done !== 1'b1 || busy !== 1'b0)
      begin n_fail++; $display("FAIL nopress_done done=%b busy=%b want 1/0", done, busy); end
    n_tests++; if (score !== 5'd0 || misses !== 5'd4)
      begin n_fail++; $display("FAIL nopress_counts score=%0d misses=%0d want 0/4", score, misses); end
  endtask

  task automatic test_hit();
    bit ok;
    int idx;
    logic [4:0] e5;
    start = 1'b1; tick(); start = 1'b0;
    n_tests++; if (done !== 1'b0 || busy !== 1'b1)
      begin n_fail++; $display("FAIL restart done=%b busy=%b want 0/1", done, busy); end
    wait_lit(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL hit_lit_timeout"); return; end
    idx = onehot_idx(mole);
    repeat (4) tick();
    btn[idx] = 1'b0;
    exp_q.push_back(1);
    repeat (3) tick();
    n_tests++; if (hit !== 1'b0 || mole == 4'd0)
      begin n_fail++; $display("FAIL hit_early hit=%b mole=%b want 0/lit", hit, mole); end
    tick();
    n_tests++; if (hit !== 1'b1 || mole !== 4'd0)
      begin n_fail++; $display("FAIL hit_latency hit=%b mole=%b want 1/0000", hit, mole); end
    if (hit === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL hit_unexpected score=%0d", score); end
      else begin
        e5 = 5'(exp_q.pop_front());
        if (score !== e5) begin n_fail++; $display("FAIL hit_score got %0d want %0d", score, e5); end
      end
    end
    tick();
    n_tests++; if (hit !== 1'b0) begin n_fail++; $display("FAIL hit_pulse_width got %b want 0", hit); end
    btn = 4'hF;
  endtask

  task automatic test_miss_then_hit();
    bit ok;
    int idx, other;
    logic [4:0] e5;
    wait_lit(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL miss_lit_timeout"); return; end
    idx = onehot_idx(mole);
    other = (idx + 1) % 4;
    btn[other] = 1'b0;
    repeat (4) tick();
    n_tests++; if (misses !== 5'd1 || mole == 4'd0)
      begin n_fail++; $display("FAIL miss_count misses=%0d mole=%b want 1/lit", misses, mole); end
    repeat (6) tick();
    n_tests++; if (misses !== 5'd1)
      begin n_fail++; $display("FAIL miss_held misses=%0d want 1", misses); end
    btn = 4'hF;
    tick();
    btn[idx] = 1'b0;
    exp_q.push_back(2);
    repeat (4) tick();
    n_tests++; if (hit !== 1'b1 || misses !== 5'd1)
      begin n_fail++; $display("FAIL miss_then_hit hit=%b misses=%0d want 1/1", hit, misses); end
    if (hit === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL hit_unexpected score=%0d", score); end
      else begin
        e5 = 5'(exp_q.pop_front());
        if (score !== e5) begin n_fail++; $display("FAIL miss_hit_score got %0d want %0d", score, e5); end
      end
    end
    btn = 4'hF;
  endtask

  task automatic test_timeout_hit();
    bit ok;
    int idx;
    logic [4:0] e5;
    wait_lit(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL tmo_lit_timeout"); return; end
    idx = onehot_idx(mole);
    repeat (16) tick();
    btn[idx] = 1'b0;
    exp_q.push_back(3);
    repeat (3) tick();
    n_tests++; if (mole == 4'd0 || hit !== 1'b0)
      begin n_fail++; $display("FAIL tmo_early mole=%b hit=%b want lit/0", mole, hit); end
    tick();
    n_tests++; if (hit !== 1'b1 || misses !== 5'd1 || mole !== 4'd0)
      begin n_fail++; $display("FAIL tmo_hit hit=%b misses=%0d mole=%b want 1/1/0000", hit, misses, mole); end
    if (hit === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL hit_unexpected score=%0d", score); end
      else begin
        e5 = 5'(exp_q.pop_front());
        if (score !== e5) begin n_fail++; $display("FAIL tmo_score got %0d want %0d", score, e5); end
      end
    end
    // button stays held through the last show: must not register again
    for (int i = 0; i < 200 && done !== 1'b1; i++) tick();
    n_tests++; if (done !== 1'b1 || score !== 5'd3 || misses !== 5'd2)
      begin n_fail++; $display("FAIL round2_end done=%b score=%0d misses=%0d want 1/3/2", done, score, misses); end
    btn = 4'hF;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int idx;
    logic [4:0] e5;
    start = 1'b1; tick(); start = 1'b0;
    wait_lit(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rstmid_lit_timeout"); return; end
    idx = onehot_idx(mole);
    btn[idx] = 1'b0;
    exp_q.push_back(1);
    repeat (4) tick();
    n_tests++; if (hit !== 1'b1) begin n_fail++; $display("FAIL rstmid_hit got %b want 1", hit); end
    if (hit === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL hit_unexpected score=%0d", score); end
      else begin
        e5 = 5'(exp_q.pop_front());
        if (score !== e5) begin n_fail++; $display("FAIL rstmid_score got %0d want %0d", score, e5); end
      end
    end
    btn = 4'hF;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    n_tests++; if (busy !== 1'b1 || score !== 5'd1)
      begin n_fail++; $display("FAIL gap_start_ignored busy=%b score=%0d want 1/1", busy, score); end
    wait_lit(ok);
    n_tests++; if (!ok || score !== 5'd1)
      begin n_fail++; $display("FAIL gap_start_next_mole lit=%b score=%0d want 1/1", ok, score); end
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (mole !== 4'd0 || score !== 5'd0 || misses !== 5'd0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL async_reset mole=%b score=%0d misses=%0d busy=%b want 0", mole, score, misses, busy); end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    n_tests++; if (busy !== 1'b0 || done !== 1'b0 || mole !== 4'd0)
      begin n_fail++; $display("FAIL post_reset_idle busy=%b done=%b mole=%b want 0", busy, done, mole); end
  endtask

  task automatic test_long_round();
    bit ok;
    int idx, prev, nhit, cyc;
    logic [4:0] e5;
    start2 = 1'b1; tick(); start2 = 1'b0;
    prev = -1;
    nhit = 0;
    for (int k = 0; k < 255; k++) begin
      wait_lit2(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL long_lit_timeout at mole %0d", k); return; end
      idx = onehot_idx(mole2);
      n_tests++; if (idx < 0 || idx == prev)
        begin n_fail++; $display("FAIL long_repeat mole %0d got %b prev idx %0d", k, mole2, prev); end
      prev = idx;
      if (k < 40 && idx >= 0) begin
        btn2[idx] = 1'b0;
        nhit++;
        exp_q2.push_back((nhit > 31) ? 31 : nhit);
        cyc = 0;
        while (hit2 !== 1'b1 && cyc < 10) begin cyc++; tick(); end
        n_tests++;
        if (hit2 !== 1'b1) begin n_fail++; $display("FAIL long_hit_timeout at mole %0d", k); end
        else if (exp_q2.size() == 0) begin n_fail++; $display("FAIL long_hit_unexpected score=%0d", score2); end
        else begin
          e5 = 5'(exp_q2.pop_front());
          if (score2 !== e5) begin n_fail++; $display("FAIL long_score got %0d want %0d", score2, e5); end
        end
        btn2 = 4'hF;
      end
      cyc = 0;
      while (mole2 != 4'd0 && cyc < 20) begin cyc++; tick(); end
    end
    cyc = 0;
    while (done2 !== 1'b1 && cyc < 20) begin cyc++; tick(); end
    n_tests++; if (done2 !== 1'b1 || score2 !== 5'd31 || misses2 !== 5'd31)
      begin n_fail++; $display("FAIL long_saturate done=%b score=%0d misses=%0d want 1/31/31", done2, score2, misses2); end
    n_tests++; if (exp_q2.size() != 0 || exp_q.size() != 0)
      begin n_fail++; $display("FAIL scoreboard_leftover q1=%0d q2=%0d want 0/0", exp_q.size(), exp_q2.size()); end
  endtask

  initial begin
    test_reset();
    test_no_press();
    test_hit();
    test_miss_then_hit();
    test_timeout_hit();
    test_reset_mid();
    test_long_round();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
